// File: rtl/alu_sequencer_if.sv
// ALU command bus between the sequencer (master) and the 8-bit ALU (slave).
interface alu_sequencer_if;
    logic [7:0] alu_data;
    logic [3:0] alu_select;
    logic       alu_perform;
    logic [7:0] alu_y;

    modport master (output alu_data, output alu_select, output alu_perform, input alu_y);
    modport slave  (input alu_data, input alu_select, input alu_perform, output alu_y);
endinterface

// File: rtl/alu_sequencer.sv
// Runs a stored program of ALU operations: setup, perform pulse, settle, capture,
// four cycles per instruction, with one result per Y-producing opcode.
module alu_sequencer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              prog_we,
    input  logic [AW-1:0]     prog_addr,
    input  logic [11:0]       prog_wdata,
    input  logic [AW:0]       prog_len,
    input  logic              start,
    input  logic              abort,
    alu_sequencer_if.master   alu,
    output logic [7:0]        result,
    output logic              result_valid,
    output logic              busy,
    output logic              done,
    output logic [AW-1:0]     pc
);
    localparam int unsigned IW = 12;
    localparam int unsigned DW = 8;
    localparam int unsigned OW = 4;
    localparam logic [OW-1:0] LAST_Y_OP = 4'hC;

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_PULSE, S_HOLD, S_CAPTURE, S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [IW-1:0]    mem [DEPTH];
    logic [AW-1:0]    last_q, last_d, last_sat;
    logic [AW-1:0]    mem_addr, pc_d;
    logic [IW-1:0]    instr;
    logic [DW-1:0]    data_d, result_d;
    logic [OW-1:0]    sel_d;
    logic             perf_d, rv_d, busy_d, done_d;
    logic             prog_wr;

    // Writes are locked out while running and on the cycle a start is accepted
    assign prog_wr = prog_we && !busy && !(state == S_IDLE && start);

    always_ff @(posedge clk) begin
        if (prog_wr) mem[prog_addr] <= prog_wdata;
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= S_IDLE;
            alu.alu_data    <= '0;
            alu.alu_select  <= '0;
            alu.alu_perform <= 1'b0;
            result          <= '0;
            result_valid    <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pc              <= '0;
            last_q          <= '0;
        end else begin
            state           <= state_nxt;
            alu.alu_data    <= data_d;
            alu.alu_select  <= sel_d;
            alu.alu_perform <= perf_d;
            result          <= result_d;
            result_valid    <= rv_d;
            busy            <= busy_d;
            done            <= done_d;
            pc              <= pc_d;
            last_q          <= last_d;
        end
    end

    // Next state; abort overrides everything outside IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = (prog_len == '0) ? S_DONE : S_ISSUE;
            S_ISSUE:   state_nxt = S_PULSE;
            S_PULSE:   state_nxt = S_HOLD;
            S_HOLD:    state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = (pc == last_q) ? S_DONE : S_ISSUE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
        if (abort && state != S_IDLE) state_nxt = S_IDLE;
    end

    // Output values for the cycle being entered
    always_comb begin
        data_d   = alu.alu_data;
        sel_d    = alu.alu_select;
        perf_d   = 1'b0;
        result_d = result;
        rv_d     = 1'b0;
        busy_d   = busy;
        done_d   = 1'b0;
        pc_d     = pc;
        last_d   = last_q;

        if (prog_len >= (AW+1)'(DEPTH)) last_sat = AW'(DEPTH - 1);
        else                            last_sat = AW'(prog_len - (AW+1)'(1));

        // Instruction fetched for the ISSUE cycle about to start
        mem_addr = (state == S_IDLE) ? '0 : AW'(pc + AW'(1));
        instr    = mem[mem_addr];

        case (state_nxt)
            S_ISSUE: begin
                sel_d  = instr[11:8];
                data_d = instr[7:0];
                busy_d = 1'b1;
                if (state == S_IDLE) begin
                    pc_d   = '0;
                    last_d = last_sat;
                end else begin
                    pc_d = mem_addr;
                end
            end
            S_PULSE: perf_d = 1'b1;
            S_CAPTURE: begin
                if (alu.alu_select <= LAST_Y_OP) begin
                    result_d = alu.alu_y;
                    rv_d     = 1'b1;
                end
            end
            S_DONE: begin
                done_d = 1'b1;
                busy_d = 1'b0;
            end
            S_IDLE: busy_d = 1'b0;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: ALU stub, schedule-based reference model, per-cycle compare
// and directed program runs with hand-computed expectations.
module tb_alu_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [11:0] prog_wdata = '0;
    logic [4:0]  prog_len = '0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  result;
    logic        result_valid, busy, done;
    logic [3:0]  pc;

    int checks = 0;
    int errors = 0;

    alu_sequencer_if alu_bus ();

    alu_sequencer dut (
        .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata), .prog_len(prog_len), .start(start), .abort(abort),
        .alu(alu_bus), .result(result), .result_valid(result_valid), .busy(busy),
        .done(done), .pc(pc)
    );

    always #5 clk = ~clk;

    // ALU behaviour: ops 0..C produce Y, D/E/F move registers on perform
    function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic [7:0] d);
        case (op)
            4'h0: return 8'(a + b);
            4'h1: return 8'(a - b);
            4'h2: return a & b;
            4'h3: return a | b;
            4'h4: return a ^ b;
            4'h5: return 8'(a << 1);
            4'h6: return a >> 1;
            4'h7: return 8'(a + 8'd1);
            4'h8: return 8'(a - 8'd1);
            4'h9: return b;
            4'hA: return d;
            4'hB: return ~a;
            default: return a;
        endcase
    endfunction

    logic [7:0] st_a = '0, st_b = '0;
    always @(posedge clk) begin
        if (alu_bus.alu_perform) begin
            case (alu_bus.alu_select)
                4'hF: st_a <= alu_bus.alu_data;
                4'hE: st_b <= st_a;
                4'hD: st_a <= st_b;
                default: ;
            endcase
        end
    end
    assign alu_bus.alu_y = alu_f(alu_bus.alu_select, st_a, st_b, alu_bus.alu_data);

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: t counts cycles since an accepted start; instruction k occupies
    // cycles 4k+1..4k+4 (setup, perform, settle, capture), done lands at 4N+1.
    logic [11:0] m_prog [16];
    int          m_t = 0, m_n = 0;
    logic [7:0]  m_a = '0, m_b = '0, m_data = '0, m_res = '0;
    logic [3:0]  m_sel = '0, m_pc = '0;
    logic        m_perf = 0, m_rv = 0, m_done = 0, m_busy = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_t = 0; m_busy = 0; m_perf = 0; m_rv = 0; m_done = 0;
            m_pc = '0; m_sel = '0; m_data = '0; m_res = '0;
        end else begin
            int  k, ph;
            logic busy_now;
            if (m_perf) begin
                case (m_sel)
                    4'hF: m_a = m_data;
                    4'hE: m_b = m_a;
                    4'hD: m_a = m_b;
                    default: ;
                endcase
            end
            busy_now = (m_t != 0) && (m_t != 4 * m_n + 1);
            if (prog_we && !busy_now && !(m_t == 0 && start)) m_prog[prog_addr] = prog_wdata;
            if (m_t == 0) begin
                if (start) begin
                    m_n = (int'(prog_len) > 16) ? 16 : int'(prog_len);
                    m_t = 1;
                end
            end else if (abort || m_t == 4 * m_n + 1) m_t = 0;
            else m_t++;

            m_perf = 0; m_rv = 0; m_done = 0;
            if (m_t == 0) m_busy = 0;
            else if (m_t == 4 * m_n + 1) begin
                m_done = 1; m_busy = 0;
            end else begin
                k = (m_t - 1) / 4;
                ph = (m_t - 1) % 4;
                m_busy = 1;
                m_pc   = 4'(k);
                m_sel  = m_prog[k][11:8];
                m_data = m_prog[k][7:0];
                m_perf = (ph == 1);
                if (ph == 3 && m_sel <= 4'hC) begin
                    m_res = alu_f(m_sel, m_a, m_b, m_data);
                    m_rv  = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("alu_data", alu_bus.alu_data, m_data);
        chk("alu_select", alu_bus.alu_select, m_sel);
        chk("alu_perform", alu_bus.alu_perform, m_perf);
        chk("result", result, m_res);
        chk("result_valid", result_valid, m_rv);
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("pc", pc, m_pc);
    end

    task automatic load(input logic [3:0] a, input logic [11:0] d);
        @(posedge clk); #1 prog_we = 1'b1; prog_addr = a; prog_wdata = d;
        @(posedge clk); #1 prog_we = 1'b0;
    endtask

    task automatic do_start(input logic [4:0] len);
        @(posedge clk); #1 start = 1'b1; prog_len = len;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_alu_data"}, alu_bus.alu_data, 0);
        chk({tag, "_alu_select"}, alu_bus.alu_select, 0);
        chk({tag, "_alu_perform"}, alu_bus.alu_perform, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_result_valid"}, result_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pc"}, pc, 0);
    endtask

    logic [3:0] p1_sel, p2_sel;
    logic [7:0] p1_data, p2_data;

    // Start a program and check done timing, pulse counts, busy window and final result
    task automatic run_prog(input string tag, input logic [4:0] len, input int done_at,
                            input int n_perf, input int n_rv, input logic [7:0] res);
        int seen = 0, np = 0, nr = 0, bad_busy = 0, last_p = -10, bad_gap = 0;
        do_start(len);
        for (int i = 1; i <= done_at + 3; i++) begin
            @(negedge clk);
            if (alu_bus.alu_perform) begin
                np++;
                if (i - last_p != 4) bad_gap++;
                last_p = i;
                if (np == 1) begin p1_sel = alu_bus.alu_select; p1_data = alu_bus.alu_data; end
                if (np == 2) begin p2_sel = alu_bus.alu_select; p2_data = alu_bus.alu_data; end
            end
            if (result_valid) nr++;
            if (done && seen == 0) seen = i;
            if (busy != (i < done_at)) bad_busy++;
        end
        chk({tag, "_done_cycle"}, seen, done_at);
        chk({tag, "_perform_count"}, np, n_perf);
        chk({tag, "_perform_spacing_faults"}, (np > 1) ? bad_gap - 1 : 0, 0);
        chk({tag, "_valid_count"}, nr, n_rv);
        chk({tag, "_busy_window_faults"}, bad_busy, 0);
        chk({tag, "_result"}, result, res);
    endtask

    initial begin
        @(posedge clk); #1;
        chk_zero("reset");
        @(posedge clk); #1 reset = 1'b1;

        // Load A=5, copy to B, load A=3, Y=A+B
        load(0, 12'hF05); load(1, 12'hE00); load(2, 12'hF03); load(3, 12'h000);
        run_prog("prog4", 5'd4, 17, 4, 1, 8'h08);

        // Load A=0x0C, Y=~A
        load(0, 12'hF0C); load(1, 12'hB00);
        run_prog("prog2", 5'd2, 9, 2, 1, 8'hF3);
        chk("prog2_pulse2_select", p2_sel, 4'hB);
        chk("prog2_pulse2_data", p2_data, 8'h00);

        run_prog("len0", 5'd0, 1, 0, 0, 8'hF3);

        // Abort during the perform cycle of instruction 2
        load(0, 12'hA33); load(1, 12'hF05); load(2, 12'hE00); load(3, 12'h000);
        do_start(5'd4);
        repeat (5) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_perform", alu_bus.alu_perform, 0);
        chk("abort_result", result, 8'h33);
        begin
            int nd = 0;
            for (int i = 0; i < 8; i++) begin
                if (done) nd++;
                @(negedge clk);
            end
            chk("abort_no_done", nd, 0);
        end

        // Reset during HOLD of instruction 1, then rerun from slot 0
        load(0, 12'hF05); load(1, 12'hE00); load(2, 12'hF03); load(3, 12'h000);
        do_start(5'd4);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        #1 chk_zero("midreset");
        @(posedge clk); #1 reset = 1'b1;
        run_prog("rerun", 5'd4, 17, 4, 1, 8'h08);
        chk("rerun_first_select", p1_sel, 4'hF);
        chk("rerun_first_data", p1_data, 8'h05);

        // Write and start while busy must both be ignored
        do_start(5'd4);
        repeat (4) @(posedge clk);
        #1 prog_we = 1'b1; prog_addr = 4'd0; prog_wdata = 12'h1FF; start = 1'b1;
        @(posedge clk); #1 prog_we = 1'b0; start = 1'b0;
        begin
            int got = 0;
            for (int i = 0; i < 30 && got == 0; i++) begin
                @(negedge clk);
                if (done) got = 1;
            end
            chk("busy_ignore_done_seen", got, 1);
        end
        chk("busy_ignore_result", result, 8'h08);
        run_prog("after_ignore", 5'd4, 17, 4, 1, 8'h08);
        chk("after_ignore_slot0_select", p1_sel, 4'hF);
        chk("after_ignore_slot0_data", p1_data, 8'h05);

        // Oversized length saturates to 16 slots
        for (int i = 4; i < 16; i++) load(4'(i), {4'hA, 8'(i)});
        run_prog("saturate", 5'd31, 65, 16, 13, 8'h0F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Issues a stored program of operations to the 8-bit ALU block, driving its data, select and perform inputs and capturing its Y output. Sits upstream of the ALU as its command initiator. Host software loads a small instruction memory, pulses start, and collects one result per Y-producing operation.

Parameters:
DEPTH, 16, number of instruction slots in program memory (power of 2)
AW, 4, program address width, equal to log2(DEPTH)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
prog_we  input  1  program write strobe; ignored while busy
prog_addr  input  AW  program write address
prog_wdata  input  12  instruction: [11:8] opcode (ALU select encoding), [7:0] immediate
prog_len  input  AW+1  number of instructions to run, 0..DEPTH; sampled on accepted start
start  input  1  begin execution at slot 0; ignored while busy
abort  input  1  synchronous stop; returns to IDLE, no done pulse
alu_y  input  8  ALU Y output
alu_data  output  8  to ALU data
alu_select  output  4  to ALU select
alu_perform  output  1  to ALU perform
result  output  8  last captured Y
result_valid  output  1  one-cycle pulse when result updates
busy  output  1  high from accepted start until done or abort
done  output  1  one-cycle pulse when the program completes
pc  output  AW  index of the current instruction

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. All outputs are 0: alu_data, alu_select, alu_perform, result, result_valid, busy, done, pc. Program memory contents are not cleared.
- Program memory: DEPTH x 12, written synchronously when prog_we=1 and busy=0. Reads are combinational from pc.
- States: IDLE, ISSUE, PULSE, HOLD, CAPTURE, DONE.
- IDLE:
  - start=1 with prog_len=0 goes to DONE.
  - start=1 with prog_len>0 latches prog_len, sets pc=0, busy=1, and goes to ISSUE.
- ISSUE: alu_select and alu_data are loaded from mem[pc]. alu_perform=0 for a setup cycle.
- PULSE: alu_perform=1 for exactly one cycle. select and data are held.
- HOLD: alu_perform=0. select and data are held for one cycle so the ALU's level-sensitive select path settles.
- CAPTURE:
  - For opcodes 0000..1100: result<=alu_y and result_valid pulses in the same cycle.
  - For opcodes 1101, 1110, 1111 (internal register moves): no capture and no result_valid.
  - If pc == len-1, go to DONE. Otherwise pc increments and the next state is ISSUE.
- DONE: done=1 for one cycle, busy falls to 0 in that cycle, pc is left at its final value, next state IDLE.
- Latency: 4 cycles per instruction, from ISSUE entry to CAPTURE. A program of N instructions reaches done at cycle 4N+1 after the accepted start cycle.
- alu_select and alu_data change only on entry to ISSUE. They hold their last values in IDLE and DONE.
- alu_perform is never high on two consecutive cycles. It is never high outside PULSE.
- Simultaneous events:
  - abort wins over every other transition in every state except IDLE. It forces IDLE, alu_perform=0 and busy=0. result is retained, and no done or result_valid is issued in that cycle.
  - start while busy is ignored.
  - prog_we while busy is ignored, including prog_we in the same cycle as an accepted start.
- Reset asserted mid-program: immediate return to reset values. A subsequent start reruns from slot 0.
- prog_len > DEPTH: saturates to DEPTH.
- pc wraps only via restart; it never exceeds len-1.

Test Plan:
- Load program {F05, E00, F03, 000} with prog_len=4, then start. Required: alu_perform pulses exactly 4 times, each 4 cycles apart. result_valid pulses once with result=0x08. done pulses at cycle 17. busy is high for cycles 1..16 relative to start.
- Load {F0C, B00}, then start. Required: one result_valid with result=0xF3. alu_select is 0xB and alu_data is 0x00 during the second PULSE.
- prog_len=0 with start. Required: done pulses on the next cycle, alu_perform is never asserted, busy stays 0 except for no cycle.
- Assert abort during the PULSE of instruction 2 of a 4-instruction program. Required: next cycle is IDLE with busy=0 and alu_perform=0, no done. result still holds the instruction-1 value.
- Assert reset low during HOLD. Required: all outputs are 0 immediately, without waiting for clk. After release, start reruns from pc=0 and memory is intact.
- Assert prog_we to slot 0 with data 0x1FF and start in the same cycle while busy. Required: both are ignored. The memory readback and results match the original program.
